fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the pipeline front end.
- Owns the PA-RISC style PC/nPC pair and drives the byte address of the 256-byte, big-endian instruction ROM, which returns a 32-bit word combinationally.
- Registers the returned word into the IF/ID stage.
- Honours hazard-unit stalls, branch redirects with a delay slot and optional delay-slot nullification, and a halt request.

Parameters:
- ADDR_W, 8: width of the ROM byte address, PC and nPC.
- RESET_PC, 0: PC value loaded on reset.
- STEP, 4: byte increment per instruction.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  ADDR_W  byte address to the instruction ROM; equals PC combinationally.
- rom_data  input  32  instruction word returned by the ROM for rom_addr.
- stall  input  1  hazard unit holds IF; 1 freezes PC, nPC and the IF/ID register.
- redirect  input  1  taken branch or jump; nPC is replaced by redirect_target.
- redirect_target  input  ADDR_W  branch target byte address.
- nullify  input  1  sampled with redirect; squashes the delay-slot instruction.
- halt_req  input  1  stop fetching permanently until reset.
- pc  output  ADDR_W  current PC.
- npc  output  ADDR_W  current nPC.
- if_instr  output  32  IF/ID instruction register.
- if_pc  output  ADDR_W  address of if_instr.
- if_valid  output  1  if_instr is a live instruction.
- halted  output  1  state is HALTED.

Behaviour:
- Reset: reset=1 at a clock edge overrides every other input, including mid-stall, a pending redirect, or HALTED. On that edge:
  - PC=RESET_PC, nPC=RESET_PC+STEP.
  - if_instr=0, if_pc=0, if_valid=0, halted=0.
  - Pending-redirect register cleared; state=START.
- States:
  - START: one cycle; no capture, if_valid=0, PC/nPC held. Always goes to FETCH.
  - FETCH: normal operation.
  - HALTED: PC, nPC and if_instr frozen; if_valid=0; halted=1. Exit only via reset.
- FETCH edge with stall=0:
  - if_instr<=rom_data, if_pc<=PC.
  - if_valid<=~squash, where squash is a registered flag.
  - PC<=nPC.
  - nPC<=effective target if a redirect is effective, else nPC+STEP.
  - Delay slot: the instruction at the old nPC always follows a branch, so exactly one delay slot exists.
- Effective redirect: redirect input this cycle, or the pending register.
  - Its nullify value sets squash for the next capture only. That next capture is the delay slot: the instruction at the old nPC.
  - squash clears after one capture.
- FETCH edge with stall=1:
  - if_*, PC and nPC hold.
  - A redirect arriving during stall is latched into the pending register (target plus nullify), most recent wins.
  - The pending redirect is applied at the first stall=0 edge.
  - The pending register clears when applied.
- Redirect at the same edge as stall=0 and a pending entry: the live input wins; the pending entry is discarded.
- Alignment: the low 2 bits of redirect_target are forced to 0 before use.
- Arithmetic: PC and nPC arithmetic is modulo 2^ADDR_W. 0xFC+4 wraps to 0x00 with no flag.
- halt_req=1 in FETCH: next edge goes to HALTED, clears if_valid, and performs no capture. This holds regardless of stall or redirect.
- halt_req in START is also honoured: START goes to HALTED.
- rom_addr=PC in every state. The latency from PC to if_instr is one edge.

Test Plan:
- Reset, then run 6 cycles with stall=0 and ROM holding words W0..W3 at 0x00..0x0C:
  - START cycle shows if_valid=0.
  - Then if_pc follows 0x00, 0x04, 0x08, 0x0C with if_instr W0..W3 and if_valid=1.
- Branch: pulse redirect=1, target=0x40, nullify=0 while PC=0x08:
  - Captures occur at 0x08, 0x0C (delay slot, valid), then 0x40, 0x44.
- Same as above with nullify=1: the 0x0C capture has if_valid=0, and the 0x40 capture has if_valid=1.
- Redirect during stall:
  - Hold stall=1 for 3 cycles starting at PC=0x10.
  - Pulse redirect to 0x23 in the middle cycle.
  - Outputs frozen throughout the stall.
  - After release, captures occur at 0x10, 0x14, 0x20 (target aligned).
- Wrap: redirect to 0xF8 gives captures 0xF8, 0xFC, 0x00, 0x04.
- halt_req=1 at PC=0x08 with stall=1:
  - Next edge: halted=1, if_valid=0, PC stays 0x08.
  - Stays halted for 10 cycles.
  - Then reset=1 for one edge gives PC=0x00, state=START.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/nPC instruction-fetch sequencer with delay-slot redirect, stall and halt
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   rom_addr / rom_data         byte address out (always PC), 32-bit big-endian word back
//   stall                       freeze PC, nPC and the IF/ID register
//   redirect, redirect_target   taken branch: replaces nPC (target word-aligned)
//   nullify                     sampled with redirect: squash the delay-slot capture
//   halt_req                    stop fetching until reset
//   pc, npc                     current PC / nPC
//   if_instr, if_pc, if_valid   IF/ID register contents
//   halted                      sequencer is in the halted state
module fetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int STEP     = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              nullify,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_INIT    = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t state;
    state_t state_nxt;

    // FSM-derived controls
    logic capture;      // IF/ID load and PC/nPC advance
    logic latch_pend;   // redirect arriving while stalled
    logic halt_enter;   // leaving FETCH/START for HALTED

    // Redirect remembered across a stall; most recent one wins.
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              pend_nullify;

    // Set by a nullifying redirect, consumed by the next (delay-slot) capture.
    logic squash;

    logic              eff_redirect;
    logic [ADDR_W-1:0] eff_target;
    logic              eff_nullify;

    assign rom_addr = pc;

    // A live redirect overrides any pending one.
    assign eff_redirect = redirect | pend_valid;
    assign eff_target   = redirect ? (redirect_target & ALIGN_MASK) : pend_target;
    assign eff_nullify  = redirect ? nullify : pend_nullify;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_START;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_START:  state_nxt = halt_req ? ST_HALTED : ST_FETCH;
            ST_FETCH:  state_nxt = halt_req ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_START;
        endcase
    end

    always_comb begin
        capture    = 1'b0;
        latch_pend = 1'b0;
        halt_enter = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_START: begin
                halt_enter = halt_req;
            end
            ST_FETCH: begin
                halt_enter = halt_req;
                capture    = ~halt_req & ~stall;
                latch_pend = ~halt_req & stall & redirect;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= PC_INIT;
            npc          <= PC_INIT + PC_STEP;
            if_instr     <= 32'd0;
            if_pc        <= '0;
            if_valid     <= 1'b0;
            squash       <= 1'b0;
            pend_valid   <= 1'b0;
            pend_target  <= '0;
            pend_nullify <= 1'b0;
        end else if (halt_enter) begin
            if_valid <= 1'b0;
        end else if (capture) begin
            if_instr   <= rom_data;
            if_pc      <= pc;
            if_valid   <= ~squash;
            pc         <= npc;
            pend_valid <= 1'b0;
            if (eff_redirect) begin
                npc    <= eff_target;
                squash <= eff_nullify;
            end else begin
                npc    <= npc + PC_STEP;
                squash <= 1'b0;
            end
        end else if (latch_pend) begin
            pend_valid   <= 1'b1;
            pend_target  <= redirect_target & ALIGN_MASK;
            pend_nullify <= nullify;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed bench for fetch_sequencer against a behavioural model
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_target;
    logic        nullify;
    logic        halt_req;
    logic [7:0]  pc;
    logic [7:0]  npc;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        halted;

    logic [7:0] rom [256];

    int checks = 0;
    int errors = 0;

    // model state: a fetch stream described as "where am I, where next"
    logic [7:0]  m_pc, m_npc, m_if_pc;
    logic [31:0] m_if_instr;
    logic        m_if_valid, m_halted, m_running, m_squash;
    logic        m_pend;
    logic [7:0]  m_pend_tgt;
    logic        m_pend_null;

    fetch_sequencer #(.ADDR_W(8), .RESET_PC(0), .STEP(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .nullify         (nullify),
        .halt_req        (halt_req),
        .pc              (pc),
        .npc             (npc),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_valid        (if_valid),
        .halted          (halted)
    );

    assign rom_data = {rom[rom_addr], rom[rom_addr + 8'd1], rom[rom_addr + 8'd2], rom[rom_addr + 8'd3]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [7:0] b1, b2, b3;
        b1 = a + 8'd1;
        b2 = a + 8'd2;
        b3 = a + 8'd3;
        return {rom[a], rom[b1], rom[b2], rom[b3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] nxt;
        if (reset) begin
            m_pc = 8'h00; m_npc = 8'h04;
            m_if_instr = 32'd0; m_if_pc = 8'h00; m_if_valid = 1'b0;
            m_halted = 1'b0; m_running = 1'b0; m_squash = 1'b0;
            m_pend = 1'b0; m_pend_tgt = 8'h00; m_pend_null = 1'b0;
        end else if (m_halted) begin
            // frozen
        end else if (!m_running) begin
            m_running = 1'b1;
            if (halt_req) m_halted = 1'b1;
        end else if (halt_req) begin
            m_halted = 1'b1;
            m_if_valid = 1'b0;
        end else if (stall) begin
            if (redirect) begin
                m_pend = 1'b1;
                m_pend_tgt = {redirect_target[7:2], 2'b00};
                m_pend_null = nullify;
            end
        end else begin
            m_if_instr = word_at(m_pc);
            m_if_pc = m_pc;
            m_if_valid = !m_squash;
            if (redirect) begin
                nxt = {redirect_target[7:2], 2'b00};
                m_squash = nullify;
            end else if (m_pend) begin
                nxt = m_pend_tgt;
                m_squash = m_pend_null;
            end else begin
                nxt = m_npc + 8'd4;
                m_squash = 1'b0;
            end
            m_pend = 1'b0;
            m_pc = m_npc;
            m_npc = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pc", {24'd0, pc}, {24'd0, m_pc});
        check("npc", {24'd0, npc}, {24'd0, m_npc});
        check("rom_addr", {24'd0, rom_addr}, {24'd0, m_pc});
        check("if_instr", if_instr, m_if_instr);
        check("if_pc", {24'd0, if_pc}, {24'd0, m_if_pc});
        check("if_valid", {31'd0, if_valid}, {31'd0, m_if_valid});
        check("halted", {31'd0, halted}, {31'd0, m_halted});
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_target = 8'h00; nullify = 1'b0; halt_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // one capture edge with an optional redirect, then check the captured address
    task automatic cap(input string tag, input logic [7:0] exp_pc, input logic exp_valid);
        tick();
        redirect = 1'b0;
        check(tag, {24'd0, if_pc}, {24'd0, exp_pc});
        check({tag, "_v"}, {31'd0, if_valid}, {31'd0, exp_valid});
    endtask

    int halted_for;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        idle_inputs();

        // basic sequential fetch
        do_reset();
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_npc", {24'd0, npc}, 32'h04);
        tick();
        check("start_valid", {31'd0, if_valid}, 32'd0);
        check("start_pc", {24'd0, pc}, 32'h00);
        cap("seq0", 8'h00, 1'b1);
        check("seq0_instr", if_instr, word_at(8'h00));
        cap("seq1", 8'h04, 1'b1);
        cap("seq2", 8'h08, 1'b1);
        cap("seq3", 8'h0C, 1'b1);
        check("seq3_instr", if_instr, word_at(8'h0C));

        // branch with and without nullify, pulsed while PC=0x08
        for (int n = 0; n < 2; n++) begin
            do_reset();
            tick();
            cap("br_a", 8'h00, 1'b1);
            cap("br_b", 8'h04, 1'b1);
            check("br_pc8", {24'd0, pc}, 32'h08);
            redirect = 1'b1; redirect_target = 8'h40; nullify = (n == 1);
            cap("br_08", 8'h08, 1'b1);
            nullify = 1'b0;
            cap("br_ds", 8'h0C, (n == 0));
            cap("br_40", 8'h40, 1'b1);
            cap("br_44", 8'h44, 1'b1);
        end

        // redirect during a 3-cycle stall at PC=0x10
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("st_pc10", {24'd0, pc}, 32'h10);
        stall = 1'b1;
        tick();
        redirect = 1'b1; redirect_target = 8'h23;
        tick();
        redirect = 1'b0;
        tick();
        check("st_frozen", {24'd0, if_pc}, 32'h0C);
        stall = 1'b0;
        cap("st_10", 8'h10, 1'b1);
        cap("st_14", 8'h14, 1'b1);
        cap("st_20", 8'h20, 1'b1);

        // wrap around the top of the ROM
        redirect = 1'b1; redirect_target = 8'hF8;
        cap("wr_24", 8'h24, 1'b1);
        cap("wr_ds", 8'h28, 1'b1);
        cap("wr_f8", 8'hF8, 1'b1);
        cap("wr_fc", 8'hFC, 1'b1);
        cap("wr_00", 8'h00, 1'b1);
        cap("wr_04", 8'h04, 1'b1);

        // halt while stalled at PC=0x08
        do_reset();
        tick();
        tick();
        tick();
        halt_req = 1'b1; stall = 1'b1;
        tick();
        check("halt_h", {31'd0, halted}, 32'd1);
        check("halt_v", {31'd0, if_valid}, 32'd0);
        check("halt_pc", {24'd0, pc}, 32'h08);
        halt_req = 1'b0; stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            redirect = i[0];
            redirect_target = 8'h80;
            tick();
            check("halt_hold", {31'd0, halted}, 32'd1);
        end
        do_reset();
        check("halt_rst_pc", {24'd0, pc}, 32'h00);
        check("halt_rst_h", {31'd0, halted}, 32'd0);
        tick();
        check("halt_start_v", {31'd0, if_valid}, 32'd0);

        // randomized traffic, including reset overriding stall/pending/halted
        halted_for = 0;
        for (int i = 0; i < 3000; i++) begin
            stall           = ($urandom_range(0, 3) == 0);
            redirect        = ($urandom_range(0, 6) == 0);
            redirect_target = 8'($urandom);
            nullify         = $urandom_range(0, 1) == 1;
            halt_req        = ($urandom_range(0, 80) == 0);
            reset           = ($urandom_range(0, 120) == 0) || (halted_for > 4);
            tick();
            halted_for = halted ? halted_for + 1 : 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
